operand_deserializer: RTL and testbench

//  Serial-to-parallel operand source for the CA1 datapath registers (sload/pin style).
//  - Collects a WIDTH-bit operand arriving one bit per accepted cycle, LSB first.
//  - Presents the word on pout and issues a single-cycle sload so the destination register captures it.
//  - Sits between the operand input stream and a parallel-load register (e.g. register B).

---
 rtl/ca1_pkg.sv | 8 +
 rtl/sipo_shifter.sv | 34 +++
 rtl/operand_deserializer.sv | 131 +++++++++++++
 tb/tb_operand_deserializer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ca1_pkg.sv
// Shared types and defaults for the CA1 operand path.
package ca1_pkg;

   typedef enum logic [2:0] {IDLE, SHIFT, CHECK, FULL, LOAD} deser_state_t;

   localparam int unsigned DESER_DEFAULT_WIDTH = 5;

endpackage

// File: rtl/sipo_shifter.sv
// LSB-first serial-in/parallel-out shift register with an accepted-bit counter.
module sipo_shifter #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic             sin,
   input  logic             clr,
   output logic [WIDTH-1:0] word,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] word_q;
   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_q  <= '0;
         count_q <= '0;
      end else if (clr) begin
         word_q  <= '0;
         count_q <= '0;
      end else if (shift_en) begin
         word_q  <= {sin, word_q[WIDTH-1:1]};
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign word  = word_q;
   assign count = count_q;

endmodule

// File: rtl/operand_deserializer.sv
// Serial-to-parallel operand source issuing a one-cycle sload to a parallel-load register.
// Optional even-parity check on each word when PARITY_CHK_EN is defined (adds port perr).
module operand_deserializer
   import ca1_pkg::*;
#(
   parameter  int unsigned WIDTH = DESER_DEFAULT_WIDTH,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_valid,
   output logic             sin_ready,
   input  logic             dst_ready,
   output logic [WIDTH-1:0] pout,
   output logic             sload,
   output logic             busy
`ifdef PARITY_CHK_EN
   ,
   output logic             perr
`endif
);

   deser_state_t     state_q, state_d;
   logic [WIDTH-1:0] pout_q, pout_d;
   logic [WIDTH-1:0] word;
   logic [CNT_W-1:0] count;
   logic             accept;
   logic             shift_en;
   logic             clr;
   logic             last_bit;
   logic [WIDTH-1:0] next_word;

   assign accept    = sin_valid && sin_ready;
   assign next_word = {sin, word[WIDTH-1:1]};
   assign last_bit  = accept && (count == CNT_W'(WIDTH - 1));
   // The parity bit is consumed in CHECK but never enters the data shifter.
   assign shift_en  = accept && (state_q != CHECK);

   sipo_shifter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_shifter (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shift_en),
      .sin      (sin),
      .clr      (clr),
      .word     (word),
      .count    (count)
   );

`ifdef PARITY_CHK_EN
   logic perr_q, perr_d;
`endif

   always_comb begin
      state_d = state_q;
      pout_d  = pout_q;
      clr     = 1'b0;
`ifdef PARITY_CHK_EN
      perr_d  = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = SHIFT;
         end
         SHIFT: begin
            if (last_bit) begin
`ifdef PARITY_CHK_EN
               state_d = CHECK;
`else
               state_d = FULL;
               pout_d  = next_word;
`endif
            end
         end
`ifdef PARITY_CHK_EN
         CHECK: begin
            if (accept) begin
               if ((^word ^ sin) == 1'b0) begin
                  pout_d  = word;
                  state_d = FULL;
               end else begin
                  perr_d  = 1'b1;
                  clr     = 1'b1;
                  state_d = IDLE;
               end
            end
         end
`endif
         FULL: begin
            if (dst_ready) state_d = LOAD;
         end
         LOAD: begin
            clr     = 1'b1;
            state_d = IDLE;
         end
         default: begin
            clr     = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pout_q  <= '0;
      end else begin
         state_q <= state_d;
         pout_q  <= pout_d;
      end
   end

`ifdef PARITY_CHK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) perr_q <= 1'b0;
      else      perr_q <= perr_d;
   end
   assign perr = perr_q;
   assign sin_ready = (state_q == IDLE) || (state_q == SHIFT) || (state_q == CHECK);
`else
   assign sin_ready = (state_q == IDLE) || (state_q == SHIFT);
`endif

   assign sload = (state_q == LOAD);
   assign busy  = (state_q != IDLE);
   assign pout  = pout_q;

endmodule

// File: tb/tb_operand_deserializer.sv
// Directed bench for operand_deserializer (WIDTH=5): vector table plus reset/parity sequences.
module tb_operand_deserializer;

   localparam int unsigned W = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic         sin;
   logic         sin_valid;
   logic         sin_ready;
   logic         dst_ready;
   logic [W-1:0] pout;
   logic         sload;
   logic         busy;
`ifdef PARITY_CHK_EN
   logic         perr;
`endif

   operand_deserializer #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .sin       (sin),
      .sin_valid (sin_valid),
      .sin_ready (sin_ready),
      .dst_ready (dst_ready),
      .pout      (pout),
      .sload     (sload),
      .busy      (busy)
`ifdef PARITY_CHK_EN
      ,
      .perr      (perr)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] prev_pout = '0;

   typedef struct {
      logic [W-1:0] bits;      // bits[0] is sent first
      logic [9:0]   gaps;      // 2-bit idle-cycle count before each bit
      int unsigned  hold;      // cycles in FULL with dst_ready low
      logic         dst_early; // dst_ready held high while shifting
      logic [W-1:0] exp_pout;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_word(input vec_t v, input int idx);
      int unsigned cycles;
      int unsigned exp_cycles;
      cycles     = 0;
      exp_cycles = W + 2 + v.hold;
`ifdef PARITY_CHK_EN
      exp_cycles++;
`endif
      dst_ready = v.dst_early;
      for (int i = 0; i < int'(W); i++) begin
         logic [1:0] g;
         g = v.gaps[2*i +: 2];
         exp_cycles += g;
         for (int k = 0; k < int'(g); k++) begin
            sin_valid = 1'b0;
            sin       = ~v.bits[i];
            tick();
            cycles++;
         end
         chk($sformatf("v%0d_ready_b%0d", idx, i), sin_ready, 1'b1);
         chk($sformatf("v%0d_pout_hold_b%0d", idx, i), pout, prev_pout);
         sin_valid = 1'b1;
         sin       = v.bits[i];
         tick();
         cycles++;
      end
`ifdef PARITY_CHK_EN
      chk($sformatf("v%0d_check_busy", idx), busy, 1'b1);
      sin_valid = 1'b1;
      sin       = ^v.bits;
      tick();
      cycles++;
`endif
      sin_valid = 1'b0;
      chk($sformatf("v%0d_full_pout", idx), pout, v.exp_pout);
      chk($sformatf("v%0d_full_ready", idx), sin_ready, 1'b0);
      chk($sformatf("v%0d_full_busy", idx), busy, 1'b1);
      chk($sformatf("v%0d_full_sload", idx), sload, 1'b0);
      for (int k = 0; k < int'(v.hold); k++) begin
         dst_ready = 1'b0;
         sin_valid = 1'b1;
         sin       = 1'b1;
         tick();
         cycles++;
         chk($sformatf("v%0d_hold%0d_ready", idx, k), sin_ready, 1'b0);
         chk($sformatf("v%0d_hold%0d_sload", idx, k), sload, 1'b0);
         chk($sformatf("v%0d_hold%0d_pout", idx, k), pout, v.exp_pout);
      end
      dst_ready = 1'b1;
      sin_valid = 1'b0;
      tick();
      cycles++;
      chk($sformatf("v%0d_load_sload", idx), sload, 1'b1);
      chk($sformatf("v%0d_load_ready", idx), sin_ready, 1'b0);
      chk($sformatf("v%0d_load_busy", idx), busy, 1'b1);
      dst_ready = 1'b0;
      tick();
      cycles++;
      chk($sformatf("v%0d_idle_sload", idx), sload, 1'b0);
      chk($sformatf("v%0d_idle_busy", idx), busy, 1'b0);
      chk($sformatf("v%0d_idle_ready", idx), sin_ready, 1'b1);
      chk($sformatf("v%0d_idle_pout", idx), pout, v.exp_pout);
      chk($sformatf("v%0d_period", idx), cycles, exp_cycles);
      prev_pout = v.exp_pout;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      vecs[0] = '{bits: 5'b00011, gaps: 10'h000, hold: 0, dst_early: 1'b1, exp_pout: 5'd3};
      vecs[1] = '{bits: 5'b10000, gaps: 10'h000, hold: 4, dst_early: 1'b0, exp_pout: 5'd16};
      vecs[2] = '{bits: 5'b00011, gaps: 10'h024, hold: 0, dst_early: 1'b0, exp_pout: 5'd3};
      vecs[3] = '{bits: 5'b11111, gaps: 10'h101, hold: 1, dst_early: 1'b1, exp_pout: 5'd31};
      vecs[4] = '{bits: 5'b01010, gaps: 10'h000, hold: 2, dst_early: 1'b0, exp_pout: 5'd10};

      rst = 1'b0; sin = 1'b0; sin_valid = 1'b0; dst_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sin_valid = ~sin_valid;
         sin       = i[0];
         tick();
      end
      chk("rst_pout", pout, 5'd0);
      chk("rst_sload", sload, 1'b0);
      chk("rst_ready", sin_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      sin_valid = 1'b0;
      rst = 1'b1;

      for (int i = 0; i < 5; i++) run_word(vecs[i], i);

      // Abort mid-word with an asynchronous reset.
      for (int i = 0; i < 3; i++) begin
         sin_valid = 1'b1;
         sin       = 1'b1;
         tick();
      end
      chk("abort_busy_pre", busy, 1'b1);
      sin_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_ready", sin_ready, 1'b1);
      chk("abort_sload", sload, 1'b0);
      chk("abort_pout", pout, 5'd0);
      tick();
      chk("abort_sload_hold", sload, 1'b0);
      rst = 1'b1;
      prev_pout = '0;
      v = '{bits: 5'b10000, gaps: 10'h000, hold: 0, dst_early: 1'b0, exp_pout: 5'd16};
      run_word(v, 5);

`ifdef PARITY_CHK_EN
      // Even-parity mismatch: word 3 with parity bit 1.
      v = '{bits: 5'b00011, gaps: 10'h000, hold: 0, dst_early: 1'b0, exp_pout: 5'd3};
      run_word(v, 6);
      chk("perr_idle", perr, 1'b0);
      for (int i = 0; i < int'(W); i++) begin
         sin_valid = 1'b1;
         sin       = v.bits[i];
         tick();
      end
      sin = 1'b1;
      tick();
      sin_valid = 1'b0;
      chk("perr_pulse", perr, 1'b1);
      chk("perr_sload", sload, 1'b0);
      chk("perr_busy", busy, 1'b0);
      chk("perr_pout", pout, 5'd3);
      tick();
      chk("perr_clear", perr, 1'b0);
      chk("perr_no_sload", sload, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
